// File: rtl/pingpong_bank_ctrl.sv
// -----------------------------------------------------------------------------
// pingpong_bank_ctrl
//
// Purpose:
//   Controls ownership of the two group buffers (bank 0 / bank 1) shared by
//   the frame filler (writer) and the M8 frame former (reader). The reader
//   owns bank_sel and the writer owns the other bank. The two swap only on a
//   reader frame boundary (swap_req) after the writer has reported the fill
//   complete (wr_done). All RAM enables are gated here, and the read data
//   is muxed back to the reader, aligned to the RAM read latency.
//
// Parameters:
//   DATA_W - buffer word width
//   RD_LAT - RAM read latency in clk cycles (1 or 2)
//   CNT_W  - width of the saturating event counters
//
// Ports:
//   clk           system clock (clk80 domain)
//   reset         synchronous, active-high reset
//   swap_req      1-cycle pulse from the reader at the end of a group
//   wr_done       1-cycle pulse from the writer: current fill complete
//   wr_en         writer write strobe
//   rd_en         reader read strobe
//   m0_q, m1_q    bank 0 / bank 1 read data
//   bank_sel      bank owned by the reader (0 = m0); writer owns ~bank_sel
//   wr_start      1-cycle pulse: writer may start filling its bank at addr 0
//   m0_we, m1_we  gated write enables
//   m0_re, m1_re  gated read enables
//   rd_data       read data from the reader's bank, registered
//   underrun      sticky: a swap was refused because the fill was incomplete
//   underrun_cnt  saturating count of refused swaps
//   wr_drop_cnt   saturating count of wr_en cycles dropped outside FILL
//
// Build option:
//   PINGPONG_UNDERRUN_CNT_EN - when defined, underrun_cnt is a live
//   saturating counter; otherwise it is tied to zero and no register exists.
// -----------------------------------------------------------------------------
module pingpong_bank_ctrl #(
    parameter int DATA_W = 12,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              swap_req,
    input  logic              wr_done,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] m0_q,
    input  logic [DATA_W-1:0] m1_q,
    output logic              bank_sel,
    output logic              wr_start,
    output logic              m0_we,
    output logic              m1_we,
    output logic              m0_re,
    output logic              m1_re,
    output logic [DATA_W-1:0] rd_data,
    output logic              underrun,
    output logic [CNT_W-1:0]  underrun_cnt,
    output logic [CNT_W-1:0]  wr_drop_cnt
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FILL  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t              state_reg;
    logic                bank_sel_reg;
    logic                wr_start_reg;
    logic                underrun_reg;
    logic [CNT_W-1:0]    drop_cnt_reg;
    logic [RD_LAT-1:0]   sel_pipe_reg;
    logic [DATA_W-1:0]   rd_data_reg;

    logic filling;
    logic swap_refused;
    logic drop;

    assign filling      = (state_reg == ST_FILL);
    // A swap request while the fill is still running, with no wr_done in
    // the same cycle, is refused: the reader simply replays its old bank.
    assign swap_refused = swap_req & filling & ~wr_done;
    assign drop         = wr_en & ~filling;

    // -------------------------------------------------------------------------
    // Bank ownership sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_INIT;
            bank_sel_reg <= 1'b0;
            wr_start_reg <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            wr_start_reg <= 1'b0;
            case (state_reg)
                ST_INIT: begin
                    // Writer gets bank 1 first; reader sees bank 0 (stale).
                    wr_start_reg <= 1'b1;
                    state_reg    <= ST_FILL;
                end
                ST_FILL: begin
                    if (swap_req && wr_done) begin
                        // Done and swap coincide: complete the fill and swap
                        // in one step, exactly as a swap from READY.
                        bank_sel_reg <= ~bank_sel_reg;
                        wr_start_reg <= 1'b1;
                        state_reg    <= ST_FILL;
                    end else if (swap_refused) begin
                        underrun_reg <= 1'b1;
                    end else if (wr_done) begin
                        state_reg <= ST_READY;
                    end
                end
                ST_READY: begin
                    // wr_done is meaningless here and is ignored.
                    if (swap_req) begin
                        bank_sel_reg <= ~bank_sel_reg;
                        wr_start_reg <= 1'b1;
                        state_reg    <= ST_FILL;
                    end
                end
                default: begin
                    state_reg <= ST_INIT;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Dropped-write counter (saturating)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_reg <= '0;
        end else if (drop && !(&drop_cnt_reg)) begin
            drop_cnt_reg <= drop_cnt_reg + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Refused-swap counter (optional)
    // -------------------------------------------------------------------------
`ifdef PINGPONG_UNDERRUN_CNT_EN
    logic [CNT_W-1:0] underrun_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_cnt_reg <= '0;
        end else if (swap_refused && !(&underrun_cnt_reg)) begin
            underrun_cnt_reg <= underrun_cnt_reg + 1'b1;
        end
    end

    assign underrun_cnt = underrun_cnt_reg;
`else
    assign underrun_cnt = '0;
`endif

    // -------------------------------------------------------------------------
    // Read data path. The mux select follows bank_sel delayed by the RAM
    // latency, so a read issued just before a swap still returns data from
    // the bank it was issued to.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_pipe_reg <= '0;
            rd_data_reg  <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                sel_pipe_reg[i] <= sel_pipe_reg[i-1];
            end
            sel_pipe_reg[0] <= bank_sel_reg;
            rd_data_reg     <= sel_pipe_reg[RD_LAT-1] ? m1_q : m0_q;
        end
    end

    // -------------------------------------------------------------------------
    // Enable gating. reset forces every enable low so that no RAM access can
    // slip through during the cycle(s) the sequencer is being cleared.
    // -------------------------------------------------------------------------
    assign m0_we = wr_en & filling &  bank_sel_reg & ~reset;
    assign m1_we = wr_en & filling & ~bank_sel_reg & ~reset;
    assign m0_re = rd_en & ~bank_sel_reg & ~reset;
    assign m1_re = rd_en &  bank_sel_reg & ~reset;

    assign bank_sel    = bank_sel_reg;
    assign wr_start    = wr_start_reg;
    assign underrun    = underrun_reg;
    assign wr_drop_cnt = drop_cnt_reg;
    assign rd_data     = rd_data_reg;

endmodule

// File: tb/tb_pingpong_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pingpong_bank_ctrl
//
// Drives directed and random swap/fill traffic into pingpong_bank_ctrl.
// Each cycle the stimulus process advances a bank-ownership model, then
// pushes the expected outputs into a scoreboard queue; an independent
// monitor pops the queue on the falling edge and compares.
// -----------------------------------------------------------------------------
module tb_pingpong_bank_ctrl;

    localparam int DATA_W  = 12;
    localparam int RD_LAT  = 1;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              swap_req;
    logic              wr_done;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] m0_q;
    logic [DATA_W-1:0] m1_q;
    logic              bank_sel;
    logic              wr_start;
    logic              m0_we;
    logic              m1_we;
    logic              m0_re;
    logic              m1_re;
    logic [DATA_W-1:0] rd_data;
    logic              underrun;
    logic [CNT_W-1:0]  underrun_cnt;
    logic [CNT_W-1:0]  wr_drop_cnt;

    always #5 clk = ~clk;

    pingpong_bank_ctrl #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .swap_req     (swap_req),
        .wr_done      (wr_done),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .m0_q         (m0_q),
        .m1_q         (m1_q),
        .bank_sel     (bank_sel),
        .wr_start     (wr_start),
        .m0_we        (m0_we),
        .m1_we        (m1_we),
        .m0_re        (m0_re),
        .m1_re        (m1_re),
        .rd_data      (rd_data),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt),
        .wr_drop_cnt  (wr_drop_cnt)
    );

    typedef struct {
        int                cyc;
        logic              bank_sel;
        logic              wr_start;
        logic              m0_we;
        logic              m1_we;
        logic              m0_re;
        logic              m1_re;
        logic              underrun;
        logic [DATA_W-1:0] rd_data;
        logic [CNT_W-1:0]  ucnt;
        logic [CNT_W-1:0]  dcnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // ---------------- reference model (ownership view) ----------------
    bit                m_started;   // writer has been handed its first bank
    bit                m_filled;    // writer reported the current fill done
    bit                m_bank;      // bank the reader owns
    bit                m_start;     // wr_start pulse after the last edge
    bit                m_underrun;
    int                m_ucnt;
    int                m_dcnt;
    bit [DATA_W-1:0]   m_rd;
    bit                m_hist[$];   // reader bank in earlier cycles, newest first

    // inputs applied during the cycle before the next edge
    bit                p_reset = 1'b1;
    bit                p_swap, p_done, p_wen;
    bit [DATA_W-1:0]   p_m0q, p_m1q;

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic model_edge();
        if (p_reset) begin
            m_started  = 1'b0;
            m_filled   = 1'b0;
            m_bank     = 1'b0;
            m_start    = 1'b0;
            m_underrun = 1'b0;
            m_ucnt     = 0;
            m_dcnt     = 0;
            m_rd       = '0;
            m_hist.delete();
            for (int i = 0; i < RD_LAT; i++) m_hist.push_back(1'b0);
        end else begin
            // Data returned now belongs to the read issued RD_LAT cycles ago,
            // so it comes from whichever bank the reader owned back then.
            m_rd = m_hist[RD_LAT-1] ? p_m1q : p_m0q;
            m_hist.push_front(m_bank);
            void'(m_hist.pop_back());
            if (p_wen && !(m_started && !m_filled)) m_dcnt = sat_inc(m_dcnt);
            m_start = 1'b0;
            if (!m_started) begin
                m_started = 1'b1;
                m_start   = 1'b1;
            end else if (p_swap && (m_filled || p_done)) begin
                m_bank   = ~m_bank;
                m_start  = 1'b1;
                m_filled = 1'b0;
            end else if (p_swap) begin
                m_underrun = 1'b1;
                m_ucnt     = sat_inc(m_ucnt);
            end else if (p_done) begin
                m_filled = 1'b1;
            end
        end
    endtask

    // One clock of stimulus: advance the model over the edge, apply new
    // inputs, and queue what the DUT must show for this cycle.
    task automatic step(input bit rst, input bit sw, input bit dn,
                        input bit we, input bit re);
        exp_t e;
        bit   writing;
        @(posedge clk);
        #1;
        model_edge();
        reset    = rst;
        swap_req = sw;
        wr_done  = dn;
        wr_en    = we;
        rd_en    = re;
        m0_q     = DATA_W'($urandom);
        m1_q     = DATA_W'($urandom);
        writing  = m_started && !m_filled;
        e.cyc      = cyc;
        e.bank_sel = m_bank;
        e.wr_start = m_start;
        e.underrun = m_underrun;
        e.rd_data  = m_rd;
        e.dcnt     = CNT_W'(m_dcnt);
`ifdef PINGPONG_UNDERRUN_CNT_EN
        e.ucnt     = CNT_W'(m_ucnt);
`else
        e.ucnt     = '0;
`endif
        e.m0_we = we && !rst && writing &&  m_bank;
        e.m1_we = we && !rst && writing && !m_bank;
        e.m0_re = re && !rst && !m_bank;
        e.m1_re = re && !rst &&  m_bank;
        sb_q.push_back(e);
        p_reset = rst;
        p_swap  = sw;
        p_done  = dn;
        p_wen   = we;
        p_m0q   = m0_q;
        p_m1q   = m1_q;
        cyc++;
    endtask

    task automatic chk(input string name, input int c,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("bank_sel",     e.cyc, 32'(bank_sel),     32'(e.bank_sel));
                chk("wr_start",     e.cyc, 32'(wr_start),     32'(e.wr_start));
                chk("m0_we",        e.cyc, 32'(m0_we),        32'(e.m0_we));
                chk("m1_we",        e.cyc, 32'(m1_we),        32'(e.m1_we));
                chk("m0_re",        e.cyc, 32'(m0_re),        32'(e.m0_re));
                chk("m1_re",        e.cyc, 32'(m1_re),        32'(e.m1_re));
                chk("rd_data",      e.cyc, 32'(rd_data),      32'(e.rd_data));
                chk("underrun",     e.cyc, 32'(underrun),     32'(e.underrun));
                chk("underrun_cnt", e.cyc, 32'(underrun_cnt), 32'(e.ucnt));
                chk("wr_drop_cnt",  e.cyc, 32'(wr_drop_cnt),  32'(e.dcnt));
                if (e.wr_start)
                    $display("cycle %0d: wr_start, reader bank %0d, underrun %0d, drops %0d",
                             e.cyc, bank_sel, underrun, wr_drop_cnt);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset    = 1'b1;
        swap_req = 1'b0;
        wr_done  = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        m0_q     = '0;
        m1_q     = '0;

        // reset, release, INIT cycle, then fill bank 1
        repeat (3) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 1, 1);

        // three refused swaps while the fill is incomplete
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 1, 0);
            step(0, 0, 0, 0, 1);
        end

        // fill done, read bank 0 one cycle before the swap, then swap
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 1, 1);

        // done and swap together in FILL
        step(0, 1, 1, 0, 1);
        repeat (2) step(0, 0, 0, 1, 1);

        // writes in READY are dropped: 5, then long enough to saturate
        step(0, 0, 1, 0, 0);
        repeat (5) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        repeat (300) step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 1);
        repeat (2) step(0, 0, 0, 1, 1);

        // reset in the middle of a fill
        step(1, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        repeat (3) step(0, 0, 0, 1, 1);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 249) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1);
        end

        // let the monitor drain the last entry
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drain", cyc, 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pingpong_bank_ctrl.md
Name: pingpong_bank_ctrl

Overview:
Sequences the two group buffers (bank 0 / bank 1) shared between the frame filler (writer, clk80 side) and the M8 frame former (reader).
- Decides which bank the reader owns and which the writer owns, and swaps them only at a frame boundary after the writer reports completion.
- Gates all RAM read/write enables and muxes read data.
- Detects reader underrun (swap requested before the fill finished) and writes to a bank the writer does not own.

Parameters:
DATA_W, 12, buffer word width
RD_LAT, 1, RAM read latency in clk cycles (1 or 2); read-data mux select delayed by this amount
CNT_W, 8, width of saturating event counters

Ports:
clk  in  1  system clock (clk80 domain)
reset  in  1  synchronous, active-high reset
swap_req  in  1  1-cycle pulse from reader at end of group; already synchronised to clk
wr_done  in  1  1-cycle pulse from writer: current fill complete
wr_en  in  1  writer write strobe
rd_en  in  1  reader read strobe
m0_q  in  DATA_W  bank 0 read data
m1_q  in  DATA_W  bank 1 read data
bank_sel  out  1  bank currently owned by reader (0 = m0); writer owns ~bank_sel
wr_start  out  1  1-cycle pulse: writer may begin filling its bank from address 0
m0_we, m1_we  out  1  gated write enables
m0_re, m1_re  out  1  gated read enables
rd_data  out  DATA_W  read data from reader's bank, aligned to RAM latency
underrun  out  1  sticky: a swap was refused because the fill was incomplete
underrun_cnt  out  CNT_W  refused-swap count (see Optional Feature)
wr_drop_cnt  out  CNT_W  saturating count of wr_en cycles dropped outside FILL

Behaviour:
- States: INIT, FILL, READY.
- Reset values: state = INIT, bank_sel = 0, wr_start = 0, all enables = 0, underrun = 0, counters = 0, rd_data = 0.
- INIT: one cycle after reset release, pulse wr_start, then go to FILL. The writer fills bank 1 while the reader reads bank 0, which holds stale/zero data.
- FILL:
  - wr_done -> READY.
  - swap_req without wr_done -> refuse the swap: bank_sel unchanged (reader repeats the old bank), set underrun, increment underrun_cnt; stay in FILL.
  - swap_req and wr_done in the same cycle -> treat as done-then-swap; same actions as swap_req in READY.
- READY:
  - swap_req -> bank_sel toggles on the next edge; wr_start pulses on the same edge; go to FILL.
  - wr_done in READY -> ignored.
- Write gating (combinational):
  - m0_we = wr_en & (state==FILL) & (bank_sel==1).
  - m1_we = wr_en & (state==FILL) & (bank_sel==0).
  - wr_en in INIT/READY -> dropped, wr_drop_cnt += 1.
- Read gating (combinational): m0_re = rd_en & ~bank_sel; m1_re = rd_en & bank_sel.
- Read data: rd_data is registered from m0_q/m1_q using bank_sel delayed RD_LAT cycles. Reads in flight across a swap therefore return data from the bank they were issued to.
- Counters saturate at all-ones and never wrap. underrun is cleared only by reset.
- Swap latency: swap_req in READY at cycle N -> bank_sel and wr_start change at edge N+1.
- Reset asserted mid-fill: everything returns to reset values immediately (synchronous); the sequence restarts through INIT.

Optional Feature:
Macro: PINGPONG_UNDERRUN_CNT_EN.
- Defined: underrun_cnt is a live CNT_W-bit saturating counter as described.
- Undefined: underrun_cnt is tied to 0 and no counter register is built; the underrun sticky flag still operates.

Test Plan:
- Reset, release: wr_start pulses exactly once, 1 cycle after release; bank_sel = 0; wr_en -> m1_we only.
- Fill, wr_done, then swap_req at cycle N: bank_sel = 1 at N+1, wr_start pulse at N+1; wr_en now drives m0_we; rd_en drives m1_re.
- swap_req 3 times during FILL with no wr_done: bank_sel stays 0, underrun = 1, underrun_cnt = 3 (0 when the macro is undefined).
- swap_req and wr_done in the same cycle in FILL: swap occurs at the next edge; underrun stays 0.
- wr_en asserted 5 cycles in READY: no m0_we/m1_we pulse; wr_drop_cnt = 5. With CNT_W = 8 and 300 drops: wr_drop_cnt = 255.
- RD_LAT = 1: rd_en issued to bank 0 one cycle before a swap returns m0_q in rd_data after the swap; reset asserted during FILL returns all outputs to reset values on the next edge.
